iomem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the picosoc iomem bus.
- Master 0 is the picorv32 core. Master 1 is the host/SPI bridge.
- Both share the peripheral block that decodes GPIO (0x03xx_xxxx) and COUNTER (0x04xx_xxxx).
- Registered round-robin grant FSM, one transaction in flight, optional bus-hang timeout.

---
 rtl/iomem_pkg.sv | 31 +++
 rtl/iomem_arb_timeout.sv | 44 ++++
 rtl/iomem_arbiter.sv | 135 +++++++++++++
 tb/tb_iomem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared types and constants for the picosoc iomem two-master arbiter.
package iomem_pkg;

    localparam int IOMEM_AW   = 32;
    localparam int IOMEM_DW   = 32;
    localparam int IOMEM_SW   = IOMEM_DW / 8;
    localparam int TIMEOUT_CW = 16;

    localparam logic [IOMEM_DW-1:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // Complete FSM context; kept as one struct so a checker can bind to it directly.
    typedef struct packed {
        arb_state_e state;
        logic       last;
    } arb_ctx_t;

    function automatic logic [1:0] grant_of(input arb_state_e s);
        case (s)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/iomem_arb_timeout.sv
// Bus-hang watchdog for the iomem arbiter: grant-cycle counter, expiry strobe and
// sticky timeout flag. Only instantiated when IOMEM_ARB_TIMEOUT_EN is defined.
module iomem_arb_timeout
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic s_ready,
    input  logic timeout_clear,
    output logic expire,
    output logic timeout_flag
);

    localparam logic [TIMEOUT_CW-1:0] LIMIT = TIMEOUT_CW'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CW-1:0] count_q;

    // IDLE always precedes a grant, so holding the count at zero while idle
    // gives every new grant a fresh count.
    always_ff @(posedge clk) begin
        if (reset || !busy) begin
            count_q <= '0;
        end else if (!s_ready) begin
            count_q <= count_q + TIMEOUT_CW'(1);
        end
    end

    // A real completion on the last allowed cycle beats the forced one.
    assign expire = busy && !s_ready && (count_q == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (expire) begin
            timeout_flag <= 1'b1;
        end else if (timeout_clear) begin
            timeout_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter in front of the picosoc iomem peripheral block.
// Optional bus-hang timeout is built when IOMEM_ARB_TIMEOUT_EN is defined.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int unsigned         TIMEOUT_CYCLES = 255,
    parameter logic [IOMEM_DW-1:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid,
    input  logic [IOMEM_SW-1:0] m0_wstrb,
    input  logic [IOMEM_AW-1:0] m0_addr,
    input  logic [IOMEM_DW-1:0] m0_wdata,
    output logic [IOMEM_DW-1:0] m0_rdata,
    output logic                m0_ready,

    input  logic                m1_valid,
    input  logic [IOMEM_SW-1:0] m1_wstrb,
    input  logic [IOMEM_AW-1:0] m1_addr,
    input  logic [IOMEM_DW-1:0] m1_wdata,
    output logic [IOMEM_DW-1:0] m1_rdata,
    output logic                m1_ready,

    output logic                s_valid,
    output logic [IOMEM_SW-1:0] s_wstrb,
    output logic [IOMEM_AW-1:0] s_addr,
    output logic [IOMEM_DW-1:0] s_wdata,
    input  logic [IOMEM_DW-1:0] s_rdata,
    input  logic                s_ready,

    output logic [1:0]          grant,
    output logic                timeout_flag,
    input  logic                timeout_clear
);

    // Handshake: a master raises valid with stable wstrb/addr/wdata and holds
    // them until it sees a one-cycle ready pulse; rdata is only meaningful in
    // that cycle. The slave side is the same, with s_valid held for the whole
    // grant and s_ready completing it. Ready is combinational from s_ready.

    arb_ctx_t ctx_q;
    arb_ctx_t ctx_n;
    logic     expire;
    logic     done;

    assign done = s_ready || expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctx_q <= '{state: IDLE, last: 1'b1};
        end else begin
            ctx_q <= ctx_n;
        end
    end

    // On a tie the master that did not own the bus last time wins.
    always_comb begin
        ctx_n = ctx_q;
        case (ctx_q.state)
            IDLE: begin
                if (m0_valid && (!m1_valid || ctx_q.last)) begin
                    ctx_n.state = GNT0;
                    ctx_n.last  = 1'b0;
                end else if (m1_valid) begin
                    ctx_n.state = GNT1;
                    ctx_n.last  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (done) begin
                    ctx_n.state = IDLE;
                end
            end
            default: begin
                ctx_n.state = IDLE;
            end
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_wstrb  = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = grant_of(ctx_q.state);
        case (ctx_q.state)
            GNT0: begin
                s_valid  = 1'b1;
                s_wstrb  = m0_wstrb;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                m0_ready = done;
                m0_rdata = expire ? TIMEOUT_RDATA : s_rdata;
            end
            GNT1: begin
                s_valid  = 1'b1;
                s_wstrb  = m1_wstrb;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                m1_ready = done;
                m1_rdata = expire ? TIMEOUT_RDATA : s_rdata;
            end
            default: begin
            end
        endcase
    end

`ifdef IOMEM_ARB_TIMEOUT_EN
    iomem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk          (clk),
        .reset        (reset),
        .busy         (ctx_q.state != IDLE),
        .s_ready      (s_ready),
        .timeout_clear(timeout_clear),
        .expire       (expire),
        .timeout_flag (timeout_flag)
    );
`else
    // Without the watchdog a hung slave holds the bus until reset.
    logic unused_timeout;

    assign expire         = 1'b0;
    assign timeout_flag   = 1'b0;
    assign unused_timeout = &{1'b0, timeout_clear, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed, table-driven bench for iomem_arbiter; one table row per clock cycle.
module tb_iomem_arbiter;
    import iomem_pkg::*;

    typedef struct packed {
        logic        v;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        sv;
        logic [3:0]  ss;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        r0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] d1;
        logic        flag;
    } exp_t;

    typedef struct {
        logic        rst;
        req_t        m0;
        req_t        m1;
        logic        srdy;
        logic [31:0] srd;
        logic        tclr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, s_valid, s_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout_flag, timeout_clear;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    iomem_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
    );

    always #5 clk = ~clk;

    function automatic req_t rd_req(input logic [31:0] a);
        req_t r;
        r = '{v: 1'b1, s: 4'h0, a: a, d: 32'h0};
        return r;
    endfunction

    function automatic req_t wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r = '{v: 1'b1, s: s, a: a, d: d};
        return r;
    endfunction

    function automatic exp_t idle_f(input logic f);
        exp_t e;
        e = '0;
        e.flag = f;
        return e;
    endfunction

    // Expected outputs while master m owns the bus.
    function automatic exp_t eg(input int m, input req_t r, input logic rdy, input logic [31:0] rdat);
        exp_t e;
        e = '0;
        e.gnt = (m == 0) ? 2'b01 : 2'b10;
        e.sv = 1'b1;
        e.ss = r.s;
        e.sa = r.a;
        e.sd = r.d;
        if (m == 0) begin
            e.r0 = rdy;
            e.d0 = rdat;
        end else begin
            e.r1 = rdy;
            e.d1 = rdat;
        end
        return e;
    endfunction

    task automatic add(input logic rst, input req_t m0, input req_t m1, input logic srdy,
                       input logic [31:0] srd, input logic tclr, input exp_t e);
        vec_t v;
        v.rst = rst; v.m0 = m0; v.m1 = m1; v.srdy = srdy; v.srd = srd; v.tclr = tclr; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst;
        m0_valid = v.m0.v; m0_wstrb = v.m0.s; m0_addr = v.m0.a; m0_wdata = v.m0.d;
        m1_valid = v.m1.v; m1_wstrb = v.m1.s; m1_addr = v.m1.a; m1_wdata = v.m1.d;
        s_ready = v.srdy; s_rdata = v.srd; timeout_clear = v.tclr;
        #1;
        n_vec++;
        chk(idx, "grant", 32'(grant), 32'(v.e.gnt));
        chk(idx, "s_valid", 32'(s_valid), 32'(v.e.sv));
        chk(idx, "s_wstrb", 32'(s_wstrb), 32'(v.e.ss));
        chk(idx, "s_addr", s_addr, v.e.sa);
        chk(idx, "s_wdata", s_wdata, v.e.sd);
        chk(idx, "m0_ready", 32'(m0_ready), 32'(v.e.r0));
        chk(idx, "m0_rdata", m0_rdata, v.e.d0);
        chk(idx, "m1_ready", 32'(m1_ready), 32'(v.e.r1));
        chk(idx, "m1_rdata", m1_rdata, v.e.d1);
        chk(idx, "timeout_flag", 32'(timeout_flag), 32'(v.e.flag));
    endtask

    initial begin
        req_t no, r0, ca, cb, ca2, cb2, ca3, w, r2, r3, r4;
        exp_t ei;
        no  = '0;
        ei  = '0;
        r0  = rd_req(32'h0300_0000);
        ca  = rd_req(32'h0300_0010);
        cb  = wr_req(32'h0400_0000, 32'hCAFE_0001, 4'b1111);
        ca2 = wr_req(32'h0300_0014, 32'h0000_00FF, 4'b0001);
        cb2 = rd_req(32'h0400_0008);
        ca3 = rd_req(32'h0300_0018);
        w   = wr_req(32'h0400_0004, 32'h1234_5678, 4'b0011);
        r2  = rd_req(32'h0300_0008);
        r3  = rd_req(32'h0400_0010);
        r4  = rd_req(32'h0300_0020);

        // Reset state; s_ready while idle must not reach either master.
        add(1, no, no, 1, 32'hFFFF_FFFF, 0, ei);
        add(0, no, no, 1, 32'h0000_1234, 0, ei);
        // Single read, slave answers on the third grant cycle.
        add(0, r0, no, 0, 32'h0, 0, ei);
        add(0, r0, no, 0, 32'h0, 0, eg(0, r0, 0, 32'h0));
        add(0, r0, no, 0, 32'h0, 0, eg(0, r0, 0, 32'h0));
        add(0, r0, no, 1, 32'h0000_00A5, 0, eg(0, r0, 1, 32'h0000_00A5));
        add(0, no, no, 0, 32'h0, 0, ei);
        // Contention out of reset: 0,1,0,1,0 with an idle gap each time.
        add(1, no, no, 0, 32'h0, 0, ei);
        add(0, ca, cb, 0, 32'h0, 0, ei);
        add(0, ca, cb, 1, 32'h10, 0, eg(0, ca, 1, 32'h10));
        add(0, ca2, cb, 0, 32'h0, 0, ei);
        add(0, ca2, cb, 1, 32'h20, 0, eg(1, cb, 1, 32'h20));
        add(0, ca2, cb2, 0, 32'h0, 0, ei);
        add(0, ca2, cb2, 1, 32'h30, 0, eg(0, ca2, 1, 32'h30));
        add(0, ca3, cb2, 0, 32'h0, 0, ei);
        add(0, ca3, cb2, 1, 32'h40, 0, eg(1, cb2, 1, 32'h40));
        add(0, ca3, no, 0, 32'h0, 0, ei);
        add(0, ca3, no, 1, 32'h50, 0, eg(0, ca3, 1, 32'h50));
        add(0, no, no, 0, 32'h0, 0, ei);
        // m1 write passes through untouched; m0 waits behind it.
        add(0, no, w, 0, 32'h0, 0, ei);
        add(0, r2, w, 0, 32'h0, 0, eg(1, w, 0, 32'h0));
        add(0, r2, w, 0, 32'h0, 0, eg(1, w, 0, 32'h0));
        add(0, r2, w, 1, 32'h0, 0, eg(1, w, 1, 32'h0));
        add(0, r2, no, 0, 32'h0, 0, ei);
        add(0, r2, no, 1, 32'hC3C3_C3C3, 0, eg(0, r2, 1, 32'hC3C3_C3C3));
        add(0, no, no, 0, 32'h0, 0, ei);
        // Reset while GNT1 waits; the late response is dropped, then m0 wins the tie.
        add(0, no, r3, 0, 32'h0, 0, ei);
        add(0, no, r3, 0, 32'h0, 0, eg(1, r3, 0, 32'h0));
        add(1, no, r3, 0, 32'h0, 0, eg(1, r3, 0, 32'h0));
        add(0, r4, r3, 1, 32'hBAD0_0000, 0, ei);
        add(0, r4, r3, 0, 32'h0, 0, eg(0, r4, 0, 32'h0));
        add(0, r4, r3, 1, 32'h66, 0, eg(0, r4, 1, 32'h66));
        add(0, no, r3, 0, 32'h0, 0, ei);
        add(0, no, r3, 1, 32'h77, 0, eg(1, r3, 1, 32'h77));
        // Reset while GNT0 waits: reset must restore the m0-first tie break.
        add(0, r4, no, 0, 32'h0, 0, ei);
        add(0, r4, no, 0, 32'h0, 0, eg(0, r4, 0, 32'h0));
        add(1, r4, no, 0, 32'h0, 0, eg(0, r4, 0, 32'h0));
        add(0, r4, r3, 0, 32'h0, 0, ei);
        add(0, r4, r3, 1, 32'h88, 0, eg(0, r4, 1, 32'h88));
        add(0, no, no, 0, 32'h0, 0, ei);

`ifdef IOMEM_ARB_TIMEOUT_EN
        // Hung slave: forced completion on grant cycle 8, sticky flag, then clear.
        add(1, no, no, 0, 32'h0, 0, ei);
        add(0, r0, no, 0, 32'h0, 0, ei);
        for (int c = 1; c <= 8; c++)
            add(0, r0, no, 0, 32'h100 + c, 0,
                eg(0, r0, c == 8, (c == 8) ? 32'hDEAD_BEEF : 32'h100 + c));
        add(0, no, no, 0, 32'h0, 0, idle_f(1));
        add(0, no, no, 0, 32'h0, 1, idle_f(1));
        add(0, no, no, 0, 32'h0, 0, idle_f(0));
        // s_ready on the expiry cycle: normal completion, flag untouched.
        add(0, r0, no, 0, 32'h0, 0, ei);
        for (int c = 1; c <= 8; c++)
            add(0, r0, no, c == 8, 32'h200 + c, 0, eg(0, r0, c == 8, 32'h200 + c));
        add(0, no, no, 0, 32'h0, 0, idle_f(0));
        // Clear coinciding with expiry: the set wins.
        add(0, r0, no, 0, 32'h0, 0, ei);
        for (int c = 1; c <= 8; c++)
            add(0, r0, no, 0, 32'h0, c == 8,
                eg(0, r0, c == 8, (c == 8) ? 32'hDEAD_BEEF : 32'h0));
        add(0, no, no, 0, 32'h0, 0, idle_f(1));
        add(0, no, no, 0, 32'h0, 1, idle_f(1));
        add(0, no, no, 0, 32'h0, 0, idle_f(0));
`else
        // No watchdog: a slow slave is waited out and timeout_clear does nothing.
        add(0, r0, no, 0, 32'h0, 0, ei);
        for (int c = 1; c <= 12; c++)
            add(0, r0, no, 0, 32'h0, 1, eg(0, r0, 0, 32'h0));
        add(0, r0, no, 1, 32'h0000_005A, 0, eg(0, r0, 1, 32'h0000_005A));
        add(0, no, no, 0, 32'h0, 0, ei);
`endif

        reset = 1'b1;
        m0_valid = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0; timeout_clear = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
